// File: rtl/core_mem_port_pkg.sv
// Shared definitions for the core-side DRAM port: FSM state codes and
// Mem_Ctrl bit positions used by the arbiter interface.
package core_mem_port_pkg;

    typedef enum logic [1:0] {
        MP_IDLE   = 2'd0,
        MP_REQ    = 2'd1,
        MP_RDWAIT = 2'd2,
        MP_DONE   = 2'd3
    } mp_state_t;

    localparam int RDEN_BIT = 0;
    localparam int WREN_BIT = 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/core_mem_port.sv
// Core-side initiator for the shared-DRAM arbiter: issues rden/wren, waits for
// the per-core grant, captures read data after the RAM latency and stalls the core.
module core_mem_port
    import core_mem_port_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    input  logic              acq,
    output logic              timeout,
    output logic              proto_err,
    output logic [15:0]       wait_cnt
);

    localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mp_state_t         state, state_nxt;
    logic [1:0]        mem_ctrl;
    logic              is_rd;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    logic start, grant, abort, rd_done;

    assign mem_rden = mem_ctrl[RDEN_BIT];
    assign mem_wren = mem_ctrl[WREN_BIT];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        grant     = 1'b0;
        abort     = 1'b0;
        rd_done   = 1'b0;
        case (state)
            MP_IDLE: begin
                stall = cpu_rd | cpu_wr;
                if (cpu_rd | cpu_wr) begin
                    start     = 1'b1;
                    state_nxt = MP_REQ;
                end
            end
            MP_REQ: begin
                stall = 1'b1;
                // A grant on the same edge as the timeout still wins.
                if (acq) begin
                    grant     = 1'b1;
                    state_nxt = is_rd ? MP_RDWAIT : MP_DONE;
                end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
                    abort     = 1'b1;
                    state_nxt = MP_DONE;
                end
            end
            MP_RDWAIT: begin
                stall = 1'b1;
                if (lat_cnt == LAT_W'(1)) begin
                    rd_done   = 1'b1;
                    state_nxt = MP_DONE;
                end
            end
            MP_DONE:  state_nxt = MP_IDLE;
            default:  state_nxt = MP_IDLE;
        endcase
    end

    // NOTE: all state below updates with non-blocking assignments so every register
    // sees the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= MP_IDLE;
            mem_ctrl  <= '0;
            mem_addr  <= '0;
            mem_dout  <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            timeout   <= 1'b0;
            proto_err <= 1'b0;
            wait_cnt  <= '0;
            is_rd     <= 1'b0;
            lat_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            state  <= state_nxt;
            rvalid <= 1'b0;

            if (start) begin
                mem_addr           <= cpu_addr;
                mem_dout           <= cpu_wdata;
                is_rd              <= ~cpu_wr;
                mem_ctrl[WREN_BIT] <= cpu_wr;
                mem_ctrl[RDEN_BIT] <= ~cpu_wr;
                tmo_cnt            <= '0;
                if (cpu_rd & cpu_wr)
                    proto_err <= 1'b1;
            end

            if (state == MP_REQ) begin
                wait_cnt <= sat_inc16(wait_cnt);
                tmo_cnt  <= tmo_cnt + TMO_W'(1);
            end

            if (grant) begin
                mem_ctrl <= '0;
                lat_cnt  <= LAT_W'(RD_LATENCY);
            end

            if (abort) begin
                mem_ctrl <= '0;
                timeout  <= 1'b1;
                rdata    <= '1;
                rvalid   <= is_rd;
            end

            if (state == MP_RDWAIT)
                lat_cnt <= lat_cnt - LAT_W'(1);

            if (rd_done) begin
                rdata  <= mem_din;
                rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_port.sv
// Self-checking bench for core_mem_port: a core driver with a memory reference
// model, an arbiter/RAM responder, and queue-based monitors for writes and loads.
module tb_core_mem_port;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int RD_LATENCY = 1;
    localparam int TIMEOUT    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_rd, cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              mem_rden, mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem_din;
    logic              acq;
    logic              timeout, proto_err;
    logic [15:0]       wait_cnt;

    always #5 clk = ~clk;

    core_mem_port #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .stall(stall), .rdata(rdata), .rvalid(rvalid),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .acq(acq),
        .timeout(timeout), .proto_err(proto_err), .wait_cnt(wait_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] arb_mem [256];
    logic [DATA_W-1:0] rd_q [$];
    logic [15:0]       wr_q [$];

    int                cur_gdelay = 0;
    bit                park_high  = 1'b0;
    bit                exp_to, exp_pe;
    int                exp_wait;
    logic [DATA_W-1:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    // Arbiter + RAM: grants after cur_gdelay waiting REQ cycles, returns read data
    // exactly RD_LATENCY edges after the grant edge, garbage otherwise.
    initial begin : arbiter
        int age = 0;
        int pend_cnt = 0;
        logic [ADDR_W-1:0] pend_addr = '0;
        logic [15:0] exp_w;
        acq = 1'b0;
        mem_din = '0;
        forever begin
            @(negedge clk);
            mem_din = DATA_W'($urandom);
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) mem_din = arb_mem[pend_addr];
            end
            if (mem_rden === 1'b1 || mem_wren === 1'b1) begin
                age++;
                acq = (age > cur_gdelay);
            end else begin
                age = 0;
                acq = park_high ? 1'b1 : 1'($urandom);
            end
            if (acq && mem_wren === 1'b1) begin
                if (wr_q.size() == 0) fail_event("write_beat");
                else begin
                    exp_w = wr_q.pop_front();
                    check("write_beat", {mem_addr, mem_dout}, exp_w);
                end
                arb_mem[mem_addr] = mem_dout;
            end
            if (acq && mem_rden === 1'b1) begin
                pend_cnt  = RD_LATENCY;
                pend_addr = mem_addr;
            end
        end
    end

    initial begin : rd_monitor
        logic [DATA_W-1:0] exp_d;
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                if (rd_q.size() == 0) fail_event("rvalid");
                else begin
                    exp_d = rd_q.pop_front();
                    check("load_rdata", rdata, exp_d);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        @(negedge clk); #1;
        check("rst_stall", stall, 0);
        check("rst_mem_ctrl", {mem_wren, mem_rden}, 0);
        check("rst_mem_addr_dout", {mem_addr, mem_dout}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_flags", {timeout, proto_err}, 0);
        check("rst_wait_cnt", wait_cnt, 0);
        rst = 1'b0;
        exp_to = 1'b0;
        exp_pe = 1'b0;
        exp_wait = 0;
        last_rd = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cpu_rd = 1'b0;
            cpu_wr = 1'b0;
        end
    endtask

    task automatic run_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input int gd);
        bit   to;
        int   reqc, exp_stall, n;
        bit   lines_ok;
        logic [1:0] exp_lines;
        to        = (gd >= TIMEOUT);
        reqc      = to ? TIMEOUT : gd + 1;
        exp_stall = 1 + reqc + ((!wr && !to) ? RD_LATENCY : 0);
        if (wr) begin
            if (!to) begin
                ref_mem[a] = d;
                wr_q.push_back({a, d});
            end
        end else begin
            last_rd = to ? '1 : ref_mem[a];
            rd_q.push_back(last_rd);
        end
        if (to) begin
            last_rd = '1;
            exp_to  = 1'b1;
        end
        if (rd && wr) exp_pe = 1'b1;
        exp_wait = (exp_wait + reqc > 65535) ? 65535 : exp_wait + reqc;

        @(negedge clk);
        cur_gdelay = gd;
        cpu_rd = rd;
        cpu_wr = wr;
        cpu_addr = a;
        cpu_wdata = d;
        #1;
        n = 0;
        lines_ok = 1'b1;
        while (stall === 1'b1 && n < 200) begin
            exp_lines = (n >= 1 && n <= reqc) ? {wr, !wr} : 2'b00;
            if ({mem_wren, mem_rden} !== exp_lines) lines_ok = 1'b0;
            if (n >= 1 && n <= reqc && {mem_addr, mem_dout} !== {a, d}) lines_ok = 1'b0;
            n++;
            @(negedge clk); #1;
        end
        check("stall_cycles", n, exp_stall);
        check("req_lines", lines_ok, 1);
        check("wait_cnt", wait_cnt, exp_wait);
        check("timeout", timeout, exp_to);
        check("proto_err", proto_err, exp_pe);
        check("rdata_hold", rdata, last_rd);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [DATA_W-1:0] v;
        rst = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            v = DATA_W'($urandom);
            ref_mem[i] = v;
            arb_mem[i] = v;
        end
        ref_mem[8'h20] = 8'h5A;
        arb_mem[8'h20] = 8'h5A;

        @(negedge clk);
        do_reset();

        // Load, immediate grant: three stall cycles then 8'h5A.
        run_txn(1'b1, 1'b0, 8'h20, 8'h00, 0);
        idle(1);

        // Store with grant delayed 4 cycles: five REQ cycles.
        do_reset();
        run_txn(1'b0, 1'b1, 8'h10, 8'hC3, 4);
        idle(2);

        // Load with no grant at all: aborted after TIMEOUT REQ cycles.
        run_txn(1'b1, 1'b0, 8'h11, 8'h00, 255);
        idle(1);

        // Both requests high: completes as a write.
        run_txn(1'b1, 1'b1, 8'h12, 8'h9E, 2);
        idle(1);

        // Reset while the load is waiting for RAM data.
        @(negedge clk);
        cur_gdelay = 0;
        cpu_rd = 1'b1;
        cpu_wr = 1'b0;
        cpu_addr = 8'h13;
        @(negedge clk);
        @(negedge clk); #1;
        check("rdwait_stall", stall, 1);
        do_reset();
        idle(3);

        // Back-to-back loads with the grant parked high.
        park_high = 1'b1;
        run_txn(1'b1, 1'b0, 8'h10, 8'h00, 0);
        run_txn(1'b1, 1'b0, 8'h12, 8'h00, 0);
        park_high = 1'b0;
        idle(1);

        for (int i = 0; i < 40; i++) begin
            int  sel, gd;
            bit  rd, wr;
            sel = $urandom_range(0, 9);
            rd  = (sel <= 4) || (sel == 9);
            wr  = (sel >= 5);
            gd  = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 11) : $urandom_range(0, 5);
            run_txn(rd, wr, 8'($urandom_range(0, 15)), 8'($urandom), gd);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(4);
        check("rd_q_drained", rd_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
